// File: rtl/acl_paddle_ctrl.sv
// Paces the SPI accelerometer, filters the y-axis reading, and integrates the
// resulting signed velocity once per frame into a clamped paddle position.
module acl_paddle_ctrl #(
  parameter int unsigned SAMPLE_DIV    = 1000000,
  parameter int unsigned SETTLE_CYCLES = 500000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned DEADZONE      = 16,
  parameter int unsigned SPEED_SHIFT   = 4,
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned PADDLE_H      = 64
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       START,
  input  logic [9:0] Y_AXIS,
  input  logic       FRAME_TICK,
  output logic [9:0] FILT_Y,
  output logic       SAMPLE_STB,
  output logic [9:0] PADDLE_Y
);

  localparam int unsigned DEPTH   = 1 << AVG_LOG2;
  localparam int unsigned SW      = 10 + AVG_LOG2;
  localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned POS_MAX = SCREEN_H - PADDLE_H;
  localparam int unsigned POS_MID = POS_MAX / 2;

  localparam logic signed [SW-1:0] DZ      = SW'(DEADZONE);
  localparam logic signed [SW:0]   POS_TOP = (SW + 1)'(POS_MAX);

  typedef enum logic [1:0] {WAIT_DIV, PULSE, SETTLE, CAPTURE} state_t;

  state_t                   state;
  logic [DIV_W-1:0]         div_cnt;
  logic [SET_W-1:0]         set_cnt;
  logic                     div_tc;
  logic signed [9:0]        sample;
  logic                     cap;

  logic signed [9:0]        hist [DEPTH];
  logic [AVG_LOG2-1:0]      ptr;
  logic signed [SW-1:0]     sum;
  logic                     sum_stb;
  logic signed [SW-1:0]     sample_x;
  logic signed [SW-1:0]     old_x;

  logic signed [SW-1:0]     avg;
  logic signed [SW-1:0]     dz_val;
  logic signed [SW-1:0]     vel_next;
  logic signed [SW-1:0]     vel;
  logic signed [SW:0]       pos_sum;

  assign div_tc = (div_cnt == DIV_W'(SAMPLE_DIV));

  // The divider free-runs in every state, so the terminal count can also land
  // in CAPTURE when SETTLE_CYCLES is close to SAMPLE_DIV.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= WAIT_DIV;
      div_cnt <= '0;
      set_cnt <= '0;
      START   <= 1'b0;
      sample  <= '0;
      cap     <= 1'b0;
    end else begin
      START   <= 1'b0;
      cap     <= 1'b0;
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      case (state)
        WAIT_DIV: begin
          if (div_tc) begin
            state <= PULSE;
            START <= 1'b1;
          end
        end
        PULSE: begin
          state   <= SETTLE;
          set_cnt <= '0;
        end
        SETTLE: begin
          if (set_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state  <= CAPTURE;
            sample <= Y_AXIS;
            cap    <= 1'b1;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (div_tc) begin
            state <= PULSE;
            START <= 1'b1;
          end else begin
            state <= WAIT_DIV;
          end
        end
        default: state <= WAIT_DIV;
      endcase
    end
  end

  always_comb begin
    sample_x = {{AVG_LOG2{sample[9]}}, sample};
    old_x    = {{AVG_LOG2{hist[ptr][9]}}, hist[ptr]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      ptr     <= '0;
      sum     <= '0;
      sum_stb <= 1'b0;
    end else begin
      sum_stb <= cap;
      if (cap) begin
        hist[ptr] <= sample;
        sum       <= sum + sample_x - old_x;
        ptr       <= ptr + 1'b1;
      end
    end
  end

  // Arithmetic shifts floor toward negative on both the average and the velocity.
  always_comb begin
    avg = sum >>> AVG_LOG2;
    if (avg > DZ)       dz_val = avg - DZ;
    else if (avg < -DZ) dz_val = avg + DZ;
    else                dz_val = '0;
    vel_next = dz_val >>> SPEED_SHIFT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FILT_Y     <= '0;
      vel        <= '0;
      SAMPLE_STB <= 1'b0;
    end else begin
      SAMPLE_STB <= sum_stb;
      if (sum_stb) begin
        FILT_Y <= avg[9:0];
        vel    <= vel_next;
      end
    end
  end

  assign pos_sum = $signed({{(SW - 9){1'b0}}, PADDLE_Y}) + $signed({vel[SW-1], vel});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PADDLE_Y <= 10'(POS_MID);
    end else if (FRAME_TICK) begin
      if (pos_sum < 0)            PADDLE_Y <= '0;
      else if (pos_sum > POS_TOP) PADDLE_Y <= 10'(POS_MAX);
      else                        PADDLE_Y <= pos_sum[9:0];
    end
  end

endmodule

// File: tb/tb_acl_paddle_ctrl.sv
// Directed bench for acl_paddle_ctrl with a shortened sample period
// (SAMPLE_DIV=100, SETTLE_CYCLES=10).
module tb_acl_paddle_ctrl;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [9:0] Y_AXIS;
  logic       FRAME_TICK;
  logic [9:0] FILT_Y;
  logic       SAMPLE_STB;
  logic [9:0] PADDLE_Y;

  int vecs = 0;
  int errs = 0;
  int n;

  acl_paddle_ctrl #(
    .SAMPLE_DIV    (100),
    .SETTLE_CYCLES (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .Y_AXIS     (Y_AXIS),
    .FRAME_TICK (FRAME_TICK),
    .FILT_Y     (FILT_Y),
    .SAMPLE_STB (SAMPLE_STB),
    .PADDLE_Y   (PADDLE_Y)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (START !== 1'b1 && cnt < 400);
    assert (START === 1'b1)
    else begin
      errs++;
      $error("FAIL start_timeout observed=%0d expected=1", START);
    end
  endtask

  task automatic wait_stb(output int cnt);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (SAMPLE_STB !== 1'b1 && cnt < 400);
    assert (SAMPLE_STB === 1'b1)
    else begin
      errs++;
      $error("FAIL stb_timeout observed=%0d expected=1", SAMPLE_STB);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(negedge CLK);
      FRAME_TICK = 1'b1;
      @(negedge CLK);
      FRAME_TICK = 1'b0;
    end
  endtask

  initial begin
    RST        = 1'b1;
    Y_AXIS     = 10'h000;
    FRAME_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_start",  START,      0);
    chk("rst_stb",    SAMPLE_STB, 0);
    chk("rst_filt",   $signed(FILT_Y), 0);
    chk("rst_paddle", PADDLE_Y,   208);

    // sequencer timing
    RST = 1'b0;
    wait_start(n);
    chk("first_start", n, 101);
    @(negedge CLK);
    chk("start_width", START, 0);
    wait_stb(n);
    chk("stb_latency0", n + 1, 13);
    chk("filt_zero", $signed(FILT_Y), 0);
    Y_AXIS = 10'd200;
    wait_start(n);
    chk("start_period", n + 13, 101);

    // warm-up ramp
    wait_stb(n);
    chk("stb_latency", n, 13);
    chk("ramp1", $signed(FILT_Y), 50);
    for (int i = 2; i <= 4; i++) begin
      wait_stb(n);
      chk("ramp", $signed(FILT_Y), 50 * i);
    end

    // Y_AXIS changes outside capture are ignored
    wait_start(n);
    repeat (11) @(negedge CLK);
    Y_AXIS = 10'h200;
    wait_stb(n);
    chk("hold_filt_a", $signed(FILT_Y), 200);
    repeat (50) @(negedge CLK);
    Y_AXIS = 10'd200;
    wait_stb(n);
    chk("hold_filt_b", $signed(FILT_Y), 200);

    // positive motion and top clamp
    tick(1);
    chk("pos_1tick", PADDLE_Y, 219);
    tick(17);
    chk("pos_18tick", PADDLE_Y, 406);
    tick(1);
    chk("clamp_max", PADDLE_Y, 416);
    tick(1);
    chk("clamp_max_hold", PADDLE_Y, 416);

    // deadzone edge at -16
    wait_stb(n);
    Y_AXIS = 10'h3F0;
    repeat (4) wait_stb(n);
    chk("filt_m16", $signed(FILT_Y), -16);
    tick(10);
    chk("dz_m16_hold", PADDLE_Y, 416);

    // just outside deadzone: -17 gives vel -1
    Y_AXIS = 10'h3EF;
    repeat (4) wait_stb(n);
    chk("filt_m17", $signed(FILT_Y), -17);
    tick(1);
    chk("vel_m1", PADDLE_Y, 415);

    // negative motion and bottom clamp
    Y_AXIS = 10'h338;
    repeat (4) wait_stb(n);
    chk("filt_m200", $signed(FILT_Y), -200);
    tick(1);
    chk("neg_1tick", PADDLE_Y, 403);
    tick(33);
    chk("neg_34tick", PADDLE_Y, 7);
    tick(1);
    chk("clamp_min", PADDLE_Y, 0);
    tick(1);
    chk("clamp_min_hold", PADDLE_Y, 0);

    // deadzone edge at +16
    Y_AXIS = 10'h010;
    repeat (4) wait_stb(n);
    chk("filt_p16", $signed(FILT_Y), 16);
    tick(10);
    chk("dz_p16_hold", PADDLE_Y, 0);

    // frame tick coincides with velocity update 0 -> 2
    Y_AXIS = 10'd200;
    wait_start(n);
    repeat (12) @(negedge CLK);
    FRAME_TICK = 1'b1;
    @(negedge CLK);
    FRAME_TICK = 1'b0;
    chk("coll_stb", SAMPLE_STB, 1);
    chk("coll_filt", $signed(FILT_Y), 62);
    chk("coll_paddle", PADDLE_Y, 0);
    tick(1);
    chk("coll_next", PADDLE_Y, 2);

    // asynchronous reset during the START pulse
    wait_start(n);
    chk("pre_rst_start", START, 1);
    RST = 1'b1;
    #1;
    chk("arst_start",  START,      0);
    chk("arst_stb",    SAMPLE_STB, 0);
    chk("arst_filt",   $signed(FILT_Y), 0);
    chk("arst_paddle", PADDLE_Y,   208);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_start(n);
    chk("post_rst_start", n, 101);
    for (int i = 1; i <= 4; i++) begin
      wait_stb(n);
      chk("ramp_again", $signed(FILT_Y), 50 * i);
    end
    tick(1);
    chk("post_rst_tick", PADDLE_Y, 219);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
